yasac_arbiter: RTL and testbench

YASAC_ARBITER -- requirements
Module: yasac_arbiter

---
 rtl/yasac_arbiter.sv | 120 ++++++++++++
 tb/tb_yasac_arbiter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/yasac_arbiter.sv
// Two-requester round-robin front end for the YASAC processor: grants a job,
// sequences start/run handshakes, times out a hung processor and recovers it.
module yasac_arbiter #(
  parameter int TIMEOUT = 1000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req_a,
  input  logic [7:0] din_a,
  input  logic       req_b,
  input  logic [7:0] din_b,
  output logic       done_a,
  output logic       done_b,
  output logic [7:0] dout,
  output logic       err,
  output logic       busy,
  output logic       cpu_start,
  output logic       cpu_reset,
  output logic [7:0] cpu_data_in,
  input  logic       cpu_ready,
  input  logic [7:0] cpu_data_out
);

  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] C_TMO = CW'(TIMEOUT);

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT_LOW,
    RUN,
    DONE,
    RECOVER
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic          r_owner_b;
  logic          r_prio_b;
  logic          r_err_flag;
  logic          r_rst_hold;
  logic [CW-1:0] r_cnt;
  logic [7:0]    r_dout;
  logic [7:0]    r_data_in;

  logic          w_grant;
  logic          w_grant_b;
  logic          w_timeout;

  // With both requests up, B wins only when A was the last one served.
  always_comb begin
    w_grant   = cpu_ready & (req_a | req_b);
    w_grant_b = req_b & (~req_a | r_prio_b);
    w_timeout = ((r_state == WAIT_LOW) || (r_state == RUN)) && (r_cnt == C_TMO);
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:     if (w_grant) w_next = START;
      START:    w_next = WAIT_LOW;
      WAIT_LOW: begin
        if (w_timeout)      w_next = DONE;
        else if (!cpu_ready) w_next = RUN;
      end
      RUN: begin
        if (w_timeout || cpu_ready) w_next = DONE;
      end
      DONE:     w_next = r_err_flag ? RECOVER : IDLE;
      RECOVER:  if (cpu_ready) w_next = IDLE;
      default:  w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_owner_b  <= 1'b0;
      r_prio_b   <= 1'b0;
      r_err_flag <= 1'b0;
      r_rst_hold <= 1'b1;
      r_cnt      <= '0;
      r_dout     <= 8'h00;
      r_data_in  <= 8'h00;
    end else begin
      r_rst_hold <= 1'b0;
      r_state    <= w_next;
      case (r_state)
        IDLE: begin
          if (w_grant) begin
            r_owner_b  <= w_grant_b;
            r_data_in  <= w_grant_b ? din_b : din_a;
            r_err_flag <= 1'b0;
          end
        end
        START: r_cnt <= '0;
        WAIT_LOW, RUN: begin
          // Saturate so a long job can never wrap back under the limit.
          if (r_cnt != C_TMO) r_cnt <= r_cnt + CW'(1);
          if (w_timeout) r_err_flag <= 1'b1;
          else if ((r_state == RUN) && cpu_ready) r_dout <= cpu_data_out;
        end
        DONE: r_prio_b <= ~r_owner_b;
        default: ;
      endcase
    end
  end

  always_comb begin
    busy        = (r_state != IDLE);
    cpu_start   = (r_state == START);
    done_a      = (r_state == DONE) & ~r_owner_b;
    done_b      = (r_state == DONE) & r_owner_b;
    err         = (r_state == DONE) & r_err_flag;
    cpu_reset   = r_rst_hold | w_timeout;
    dout        = r_dout;
    cpu_data_in = r_data_in;
  end

endmodule

// File: tb/tb_yasac_arbiter.sv
// Directed bench for yasac_arbiter with a small latency-programmable processor model.
module tb_yasac_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       req_a, req_b;
  logic [7:0] din_a, din_b;
  logic       cpu_ready = 1'b1;
  logic [7:0] cpu_data_out = 8'h00;
  logic       done_a, done_b, err, busy, cpu_start, cpu_reset;
  logic [7:0] dout, cpu_data_in;

  int checks = 0;
  int errors = 0;

  int m_lat = 5;
  int m_cnt = 0;
  bit m_hang = 1'b0;
  bit m_hold = 1'b0;

  int n_start = 0;
  int n_done = 0;
  int n_overlap = 0;
  bit open_job = 1'b0;

  always #5 clk = ~clk;

  yasac_arbiter #(.TIMEOUT(20)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_a        (req_a),
    .din_a        (din_a),
    .req_b        (req_b),
    .din_b        (din_b),
    .done_a       (done_a),
    .done_b       (done_b),
    .dout         (dout),
    .err          (err),
    .busy         (busy),
    .cpu_start    (cpu_start),
    .cpu_reset    (cpu_reset),
    .cpu_data_in  (cpu_data_in),
    .cpu_ready    (cpu_ready),
    .cpu_data_out (cpu_data_out)
  );

  // Processor model: drops ready after start, raises it m_lat cycles later with 2*operand.
  always @(negedge clk) begin
    if (m_hold) cpu_ready = 1'b0;
    else if (cpu_start) begin
      cpu_ready = 1'b0;
      m_cnt = m_lat;
    end else if (!cpu_ready && !m_hang) begin
      if (m_cnt > 1) m_cnt--;
      else begin
        cpu_ready = 1'b1;
        cpu_data_out = cpu_data_in << 1;
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) open_job = 1'b0;
    else begin
      if (cpu_start) begin
        n_start++;
        if (open_job) n_overlap++;
        open_job = 1'b1;
      end
      if (done_a || done_b) begin
        n_done++;
        open_job = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_start(input string tag);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      step();
      if (cpu_start) seen = 1'b1;
    end
    chk({tag, "_start_seen"}, 32'(seen), 32'd1);
  endtask

  task automatic wait_done(input string tag, output logic got_a, output logic got_b);
    logic seen;
    seen = 1'b0;
    got_a = 1'b0;
    got_b = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      step();
      if (done_a || done_b) begin
        seen = 1'b1;
        got_a = done_a;
        got_b = done_b;
      end
    end
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
  endtask

  initial begin
    logic ga, gb, exp_a;
    int   n, s0, d0;
    bit   seen;

    reset = 1'b0;
    req_a = 1'b1;
    req_b = 1'b1;
    din_a = 8'h01;
    din_b = 8'h02;
    repeat (3) step();

    chk("rst_busy",      32'(busy),        32'd0);
    chk("rst_done_a",    32'(done_a),      32'd0);
    chk("rst_done_b",    32'(done_b),      32'd0);
    chk("rst_err",       32'(err),         32'd0);
    chk("rst_dout",      32'(dout),        32'h00);
    chk("rst_data_in",   32'(cpu_data_in), 32'h00);
    chk("rst_cpu_start", 32'(cpu_start),   32'd0);
    chk("rst_cpu_reset", 32'(cpu_reset),   32'd1);

    // Contention straight out of reset: A first, then B.
    reset = 1'b1;
    chk("rel_cpu_reset_hold", 32'(cpu_reset), 32'd1);
    step();
    chk("rel_cpu_reset_drop", 32'(cpu_reset),   32'd0);
    chk("cont_first_start",   32'(cpu_start),   32'd1);
    chk("cont_first_data_in", 32'(cpu_data_in), 32'h01);
    wait_done("cont1", ga, gb);
    chk("cont1_owner_a", 32'(ga),   32'd1);
    chk("cont1_dout",    32'(dout), 32'h02);
    chk("cont1_err",     32'(err),  32'd0);
    req_a = 1'b0;
    wait_done("cont2", ga, gb);
    chk("cont2_owner_b", 32'(gb),   32'd1);
    chk("cont2_dout",    32'(dout), 32'h04);
    req_b = 1'b0;

    // Fairness: both requesting for six jobs, last served was B.
    step();
    req_a = 1'b1;
    req_b = 1'b1;
    din_a = 8'h10;
    din_b = 8'h21;
    for (int k = 0; k < 6; k++) begin
      wait_done("fair", ga, gb);
      exp_a = ((k % 2) == 0);
      chk("fair_done_a", 32'(ga),   32'(exp_a));
      chk("fair_done_b", 32'(gb),   32'(!exp_a));
      chk("fair_dout",   32'(dout), exp_a ? 32'h20 : 32'h42);
    end
    req_a = 1'b0;
    req_b = 1'b0;

    // Single job, operand changed mid-job must not leak through.
    step();
    s0 = n_start;
    req_a = 1'b1;
    din_a = 8'h06;
    m_lat = 10;
    wait_start("single");
    din_a = 8'hFF;
    chk("single_data_in_at_start", 32'(cpu_data_in), 32'h06);
    wait_done("single", ga, gb);
    chk("single_owner_a", 32'(ga),          32'd1);
    chk("single_dout",    32'(dout),        32'h0C);
    chk("single_err",     32'(err),         32'd0);
    chk("single_data_in", 32'(cpu_data_in), 32'h06);
    req_a = 1'b0;
    step();
    chk("single_done_pulse", 32'(done_a),       32'd0);
    chk("single_one_start",  32'(n_start - s0), 32'd1);

    // Processor not ready: no grant until ready rises.
    m_hold = 1'b1;
    step();
    step();
    s0 = n_start;
    req_b = 1'b1;
    din_b = 8'h33;
    repeat (5) step();
    chk("nrdy_busy",     32'(busy),          32'd0);
    chk("nrdy_no_start", 32'(n_start - s0),  32'd0);
    m_hold = 1'b0;
    wait_done("nrdy", ga, gb);
    chk("nrdy_owner_b", 32'(gb),   32'd1);
    chk("nrdy_dout",    32'(dout), 32'h66);
    req_b = 1'b0;

    // Timeout: processor hangs, cpu_reset at count 20, error done, then recover.
    step();
    req_a = 1'b1;
    din_a = 8'h55;
    m_lat = 3;
    m_hang = 1'b1;
    wait_start("tmo");
    n = 0;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      step();
      n++;
      if (cpu_reset) seen = 1'b1;
    end
    chk("tmo_cpu_reset_seen", 32'(seen), 32'd1);
    chk("tmo_cycles",         32'(n),    32'd21);
    step();
    chk("tmo_done_a",    32'(done_a),    32'd1);
    chk("tmo_err",       32'(err),       32'd1);
    chk("tmo_dout_kept", 32'(dout),      32'h66);
    chk("tmo_rst_pulse", 32'(cpu_reset), 32'd0);
    req_a = 1'b0;
    step();
    chk("rec_busy",   32'(busy),   32'd1);
    chk("rec_done_a", 32'(done_a), 32'd0);
    chk("rec_err",    32'(err),    32'd0);
    repeat (25) step();
    chk("rec_still_busy",  32'(busy),      32'd1);
    chk("rec_no_cpu_rst",  32'(cpu_reset), 32'd0);
    m_hang = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step();
      if (!busy) seen = 1'b1;
    end
    chk("rec_back_idle", 32'(seen), 32'd1);

    // Reset during RUN aborts the job silently.
    step();
    req_b = 1'b1;
    din_b = 8'h44;
    m_lat = 10;
    wait_start("mid");
    repeat (4) step();
    chk("mid_busy_before", 32'(busy), 32'd1);
    d0 = n_done;
    reset = 1'b0;
    step();
    chk("mid_busy",      32'(busy),        32'd0);
    chk("mid_cpu_start", 32'(cpu_start),   32'd0);
    chk("mid_dout",      32'(dout),        32'h00);
    chk("mid_data_in",   32'(cpu_data_in), 32'h00);
    chk("mid_cpu_reset", 32'(cpu_reset),   32'd1);
    chk("mid_done_b",    32'(done_b),      32'd0);
    req_b = 1'b0;
    step();
    reset = 1'b1;
    repeat (15) step();
    chk("mid_no_done",  32'(n_done - d0), 32'd0);
    chk("mid_idle",     32'(busy),        32'd0);

    chk("no_overlap_start", 32'(n_overlap), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
